// File: rtl/eclair_alu_pkg.sv
// Shared constants for the ECLair 16-bit '181-style ALU: mode encodings and function selects.
// Logic-mode names are used for the op codes; arithmetic aliases are added where they are used.
package eclair_alu_pkg;

  localparam logic ALU_ARITH = 1'b0;
  localparam logic ALU_LOGIC = 1'b1;

  localparam logic [3:0] OP_NOT_A       = 4'h0;
  localparam logic [3:0] OP_NOR         = 4'h1;
  localparam logic [3:0] OP_NOT_A_AND_B = 4'h2;
  localparam logic [3:0] OP_ZERO        = 4'h3;
  localparam logic [3:0] OP_NAND        = 4'h4;
  localparam logic [3:0] OP_NOT_B       = 4'h5;
  localparam logic [3:0] OP_XOR         = 4'h6;
  localparam logic [3:0] OP_A_AND_NOT_B = 4'h7;
  localparam logic [3:0] OP_NOT_A_OR_B  = 4'h8;
  localparam logic [3:0] OP_XNOR        = 4'h9;
  localparam logic [3:0] OP_B           = 4'hA;
  localparam logic [3:0] OP_AND         = 4'hB;
  localparam logic [3:0] OP_ONES        = 4'hC;
  localparam logic [3:0] OP_A_OR_NOT_B  = 4'hD;
  localparam logic [3:0] OP_OR          = 4'hE;
  localparam logic [3:0] OP_A           = 4'hF;

  localparam logic [3:0] OP_ADD     = 4'h9;
  localparam logic [3:0] OP_SUB_DEC = 4'h6;
  localparam logic [3:0] OP_DEC     = 4'hF;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit '181 slice. Arithmetic ops are expressed as p + q + cin, where a "-1"
// term is an all-ones q so that rippled slices reproduce the full-width modular result.
module alu181_slice
  import eclair_alu_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] s,
  input  logic       cin,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] f,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] q;
  logic [3:0] lf;
  logic [4:0] sum;

  always_comb begin
    lf = 4'h0;
    unique case (s)
      4'h0: lf = ~a;
      4'h1: lf = ~(a | b);
      4'h2: lf = ~a & b;
      4'h3: lf = 4'h0;
      4'h4: lf = ~(a & b);
      4'h5: lf = ~b;
      4'h6: lf = a ^ b;
      4'h7: lf = a & ~b;
      4'h8: lf = ~a | b;
      4'h9: lf = ~(a ^ b);
      4'hA: lf = b;
      4'hB: lf = a & b;
      4'hC: lf = 4'hF;
      4'hD: lf = a | ~b;
      4'hE: lf = a | b;
      4'hF: lf = a;
      default: lf = 4'h0;
    endcase
  end

  always_comb begin
    p = a;
    q = 4'h0;
    unique case (s)
      4'h0: begin p = a;          q = 4'h0;    end
      4'h1: begin p = a | b;      q = 4'h0;    end
      4'h2: begin p = a | ~b;     q = 4'h0;    end
      4'h3: begin p = 4'h0;       q = 4'hF;    end
      4'h4: begin p = a;          q = a & ~b;  end
      4'h5: begin p = a | b;      q = a & ~b;  end
      4'h6: begin p = a;          q = ~b;      end
      4'h7: begin p = a & ~b;     q = 4'hF;    end
      4'h8: begin p = a;          q = a & b;   end
      4'h9: begin p = a;          q = b;       end
      4'hA: begin p = a | ~b;     q = a & b;   end
      4'hB: begin p = a & b;      q = 4'hF;    end
      4'hC: begin p = a;          q = a;       end
      4'hD: begin p = a | b;      q = a;       end
      4'hE: begin p = a | ~b;     q = a;       end
      4'hF: begin p = a;          q = 4'hF;    end
      default: begin p = a;       q = 4'h0;    end
    endcase
  end

  assign sum  = {1'b0, p} + {1'b0, q} + {4'h0, cin};
  assign f    = (mode == ALU_LOGIC) ? lf : sum[3:0];
  assign cout = (mode == ALU_LOGIC) ? 1'b0 : sum[4];

endmodule

// File: rtl/eclair_alu16.sv
// ECLair 16-bit ALU top: ripple-carry chain of '181 slices plus registered result and flags.
// Defining ECLAIR_ALU_FLAGS_EN adds the registered flags = {ovf, neg, zero} output.
module eclair_alu16
  import eclair_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [3:0]       alu_op,
  input  logic             c_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             a_eq_b
`ifdef ECLAIR_ALU_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int unsigned NSlice = WIDTH / 4;

  logic [NSlice:0]  carry;
  logic [WIDTH-1:0] f;

  assign carry[0] = c_in;

  for (genvar i = 0; i < NSlice; i++) begin : g_slice
    alu181_slice u_slice (
      .mode (mode),
      .s    (alu_op),
      .cin  (carry[i]),
      .a    (x[4*i +: 4]),
      .b    (y[4*i +: 4]),
      .f    (f[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z      <= '0;
      c_out  <= 1'b0;
      a_eq_b <= 1'b0;
    end else if (en) begin
      z      <= f;
      c_out  <= carry[NSlice];
      a_eq_b <= &f;
    end
  end

`ifdef ECLAIR_ALU_FLAGS_EN
  logic ovf;

  // Op 6 computes A + ~B + cin, so its operand signs differ where an add's would match.
  always_comb begin
    ovf = 1'b0;
    if (mode == ALU_ARITH) begin
      if (alu_op == OP_ADD) begin
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
      end else if (alu_op == OP_SUB_DEC) begin
        ovf = (x[WIDTH-1] != y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 3'b000;
    end else if (en) begin
      flags <= {ovf, f[WIDTH-1], (f == '0)};
    end
  end
`endif

endmodule

// File: tb/tb_eclair_alu16.sv
// Self-checking bench for eclair_alu16: table of directed vectors plus reset, hold and
// (when ECLAIR_ALU_FLAGS_EN is defined) flag sequences.
module tb_eclair_alu16;

  logic        clk;
  logic        reset;
  logic        en;
  logic        mode;
  logic [3:0]  alu_op;
  logic        c_in;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        c_out;
  logic        a_eq_b;
`ifdef ECLAIR_ALU_FLAGS_EN
  logic [2:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  eclair_alu16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .alu_op (alu_op),
    .c_in   (c_in),
    .x      (x),
    .y      (y),
    .z      (z),
    .c_out  (c_out),
    .a_eq_b (a_eq_b)
`ifdef ECLAIR_ALU_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [3:0]  op;
    logic        c_in;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp_z;
    logic        exp_c;
    logic        exp_eq;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [3:0] op, input logic ci,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mode = m; alu_op = op; c_in = ci; x = a; y = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add_00ff",  1'b0, 4'h9, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{"add_ffff",  1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{"sub",       1'b0, 4'h6, 1'b1, 16'h1234, 16'h0234, 16'h1000, 1'b1, 1'b0};
    vecs[3]  = '{"cmp_eq",    1'b0, 4'h6, 1'b0, 16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b0, 1'b1};
    vecs[4]  = '{"log_xor",   1'b1, 4'h6, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
    vecs[5]  = '{"log_and",   1'b1, 4'hB, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[6]  = '{"log_or",    1'b1, 4'hE, 1'b1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0};
    vecs[7]  = '{"log_not_a", 1'b1, 4'h0, 1'b1, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0};
    vecs[8]  = '{"dec_0",     1'b0, 4'hF, 1'b0, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
    vecs[9]  = '{"dec_1",     1'b0, 4'hF, 1'b0, 16'h0001, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{"m1_plus_c", 1'b0, 4'h3, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{"log_ones",  1'b1, 4'hC, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
    vecs[12] = '{"dbl",       1'b0, 4'hC, 1'b0, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0};
    vecs[13] = '{"ripple",    1'b0, 4'h9, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
    vecs[14] = '{"log_zero",  1'b1, 4'h3, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{"a_plus_ab", 1'b0, 4'h4, 1'b0, 16'h00F0, 16'h0030, 16'h01B0, 1'b0, 1'b0};

    reset = 1'b1; en = 1'b1; mode = 1'b1; alu_op = 4'hC; c_in = 1'b0;
    x = 16'hDEAD; y = 16'hBEEF;
    tick();
    tick();
    check("reset_z", z, 16'h0000);
    check("reset_c", {15'b0, c_out}, 16'h0);
    check("reset_eq", {15'b0, a_eq_b}, 16'h0);
`ifdef ECLAIR_ALU_FLAGS_EN
    check("reset_flags", {13'b0, flags}, 16'h0);
`endif

    // Load a nonzero result, then reset with en high must still clear it.
    @(negedge clk); reset = 1'b0;
    tick();
    check("pre_reset_z", z, 16'hFFFF);
    @(negedge clk); reset = 1'b1;
    tick();
    check("reset_over_en_z", z, 16'h0000);
    check("reset_over_en_eq", {15'b0, a_eq_b}, 16'h0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].mode, vecs[i].op, vecs[i].c_in, vecs[i].x, vecs[i].y);
      tick();
      check({vecs[i].name, "_z"}, z, vecs[i].exp_z);
      check({vecs[i].name, "_c"}, {15'b0, c_out}, {15'b0, vecs[i].exp_c});
      check({vecs[i].name, "_eq"}, {15'b0, a_eq_b}, {15'b0, vecs[i].exp_eq});
    end

    // Hold: last vector left z=01B0, c_out=0, a_eq_b=0.
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mode = 1'b1; alu_op = 4'hC; c_in = 1'b1; x = 16'h1111 * k[15:0]; y = 16'hAAAA;
      tick();
      check("hold_z", z, 16'h01B0);
      check("hold_c", {15'b0, c_out}, 16'h0);
      check("hold_eq", {15'b0, a_eq_b}, 16'h0);
    end
    @(negedge clk); en = 1'b1;
    tick();
    check("release_z", z, 16'hFFFF);
    check("release_eq", {15'b0, a_eq_b}, 16'h1);

`ifdef ECLAIR_ALU_FLAGS_EN
    drive(1'b0, 4'h9, 1'b0, 16'h7FFF, 16'h0001);
    tick();
    check("flags_ovf_z", z, 16'h8000);
    check("flags_ovf", {13'b0, flags}, 16'h0006);
    drive(1'b0, 4'h9, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("flags_zero", {13'b0, flags}, 16'h0001);
    drive(1'b0, 4'h6, 1'b1, 16'h8000, 16'h0001);
    tick();
    check("flags_sub_ovf", {13'b0, flags}, 16'h0004);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
